serial_divider: RTL and testbench

//  Sequential restoring divider (radix-2, one quotient bit per cycle); inverse counterpart of the serial adder/multiplier datapath.

---
 rtl/serial_divider.sv | 134 +++++++++++++
 tb/tb_serial_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, with start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module serial_divider #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [CW-1:0] CNT_FIN = CW'(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             zero_div;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_diff;
  logic             take;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign mag_a = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign mag_b = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
`else
  assign mag_a = dividend_i;
  assign mag_b = divisor_i;
`endif

  function automatic logic [WIDTH-1:0] fix_q(input logic [WIDTH-1:0] v);
`ifdef DIVIDER_SIGNED_EN
    return neg_q ? -v : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] fix_r(input logic [WIDTH-1:0] v);
`ifdef DIVIDER_SIGNED_EN
    return neg_r ? -v : v;
`else
    return v;
`endif
  endfunction

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
  assign p_diff  = p_shift - {1'b0, d};
  assign take    = (p_shift >= {1'b0, d});

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      p             <= '0;
      q             <= '0;
      d             <= '0;
      zero_div      <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            p             <= '0;
            q             <= mag_a;
            d             <= mag_b;
            zero_div      <= (divisor_i == '0);
            div_by_zero_o <= 1'b0;
            // A zero divisor skips the iterations and goes straight to the result step.
            cnt           <= (divisor_i == '0) ? CNT_FIN : '0;
            state         <= DIVIDE;
`ifdef DIVIDER_SIGNED_EN
            neg_q         <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            neg_r         <= dividend_i[WIDTH-1];
`endif
          end
        end
        DIVIDE: begin
          if (cnt == CNT_FIN) begin
            if (zero_div) begin
              quotient_o    <= '1;
              remainder_o   <= fix_r(q);
              div_by_zero_o <= 1'b1;
            end else begin
              quotient_o    <= fix_q(q);
              remainder_o   <= fix_r(p[WIDTH-1:0]);
            end
            state <= DONE;
          end else begin
            p   <= take ? p_diff : p_shift;
            q   <= {q[WIDTH-2:0], take};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// Directed self-checking bench for serial_divider (WIDTH=10).
module tb_serial_divider;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start = 1'b0;
  logic [9:0] dividend = '0;
  logic [9:0] divisor = '0;
  logic [9:0] quotient;
  logic [9:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;

  int tests = 0;
  int fails = 0;
  int n;
  int pulses;

  serial_divider #(.WIDTH(10)) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .busy_o       (busy),
    .done_o       (done),
    .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [9:0] a, input logic [9:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts rising edges after acceptance until done is seen; 40 means timeout.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done) break;
    end
  endtask

  task automatic count_pulses(input int cycles, output int p);
    p = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) p++;
    end
  endtask

  task automatic div_check(input string tag, input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] eq, input logic [9:0] er, input logic edbz,
                           input int elat);
    int lat;
    start_op(a, b);
    check({tag, " busy"}, busy, 1'b1);
    wait_done(lat);
    check({tag, " latency"}, lat, elat);
    check({tag, " q"}, quotient, eq);
    check({tag, " r"}, remainder, er);
    check({tag, " dbz"}, dbz, edbz);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, done, 1'b0);
    check({tag, " idle"}, busy, 1'b0);
  endtask

  initial begin
    #2;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset q", quotient, 10'd0);
    check("reset r", remainder, 10'd0);
    check("reset dbz", dbz, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;

    div_check("100/7", 10'd100, 10'd7, 10'd14, 10'd2, 1'b0, 11);
    div_check("1023/1", 10'd1023, 10'd1, 10'd1023, 10'd0, 1'b0, 11);
`ifdef DIVIDER_SIGNED_EN
    div_check("3/-1", 10'd3, 10'h3FF, 10'h3FD, 10'd0, 1'b0, 11);
`else
    div_check("3/1023", 10'd3, 10'd1023, 10'd0, 10'd3, 1'b0, 11);
`endif
    div_check("1023/1023", 10'd1023, 10'd1023, 10'd1, 10'd0, 1'b0, 11);
    div_check("5/0", 10'd5, 10'd0, 10'h3FF, 10'd5, 1'b1, 1);
    div_check("8/2", 10'd8, 10'd2, 10'd4, 10'd0, 1'b0, 11);

    // Starts during DIVIDE and during the DONE cycle must be ignored.
    start_op(10'd200, 10'd9);
    repeat (3) @(negedge clk);
    dividend = 10'd50;
    divisor  = 10'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(n);
    check("inflight done seen", done, 1'b1);
    check("inflight q", quotient, 10'd22);
    check("inflight r", remainder, 10'd2);
    dividend = 10'd60;
    divisor  = 10'd6;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    count_pulses(30, pulses);
    check("inflight extra done", pulses, 0);
    check("inflight q held", quotient, 10'd22);
    check("inflight r held", remainder, 10'd2);
    check("inflight idle", busy, 1'b0);

    // Reset in the middle of DIVIDE aborts without a done pulse.
    start_op(10'd100, 10'd7);
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset busy", busy, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort q", quotient, 10'd0);
    check("abort r", remainder, 10'd0);
    check("abort dbz", dbz, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    count_pulses(15, pulses);
    check("abort no done", pulses, 0);
    div_check("9/4", 10'd9, 10'd4, 10'd2, 10'd1, 1'b0, 11);

`ifdef DIVIDER_SIGNED_EN
    div_check("-100/7", 10'h39C, 10'd7, 10'h3F2, 10'h3FE, 1'b0, 11);
    div_check("-512/-1", 10'h200, 10'h3FF, 10'h200, 10'd0, 1'b0, 11);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
